// File: rtl/rast_pipe_pkg.sv
// Shared helpers for the rasteriser pipeline buffers.
// - DefaultDepth : default entry count for drain buffers.
// - ptr_width()  : width of a read/write pointer that indexes 0..depth-1.
// - cnt_width()  : width of an occupancy counter that holds 0..depth.
package rast_pipe_pkg;

  localparam int unsigned DefaultDepth = 4;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_drain_ram.sv
// Storage array for pipe_drain_buf: DEPTH x WIDTH registers, one synchronous
// write port and one asynchronous read port. Contents are intentionally not reset.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write address (0..DEPTH-1)
//   wdata - write data
//   raddr - read address (0..DEPTH-1)
//   rdata - combinational read data
module pipe_drain_ram
  import rast_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [ptr_width(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]              wdata,
  input  logic [ptr_width(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]              rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_drain_buf.sv
// Drain buffer at the tail of an enable-stalled pipeline. The upstream stages
// advance only while pipe_en is high; pipe_en is registered and drops as soon as
// the buffer will be full, so upstream holds its tail word instead of losing it.
// Output is first-word-fall-through.
// Build option: define PIPE_DRAIN_BYPASS_EN to forward in_data combinationally
// when the buffer is empty (same-cycle out_valid); otherwise push-to-out_valid
// latency is one cycle and there is no in-to-out combinational path.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_data, in_valid   - pipeline tail word (accepted only while pipe_en=1)
//   pipe_en             - registered advance enable for all upstream stages
//   flush               - synchronous clear of buffered data (beats push/pop)
//   out_data, out_valid - head entry, out_ready pops it
//   count               - current occupancy
module pipe_drain_buf
  import rast_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_valid,
  output logic                        pipe_en,
  input  logic                        flush,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = cnt_width(DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             pipe_en_q, pipe_en_d;
  logic             push, wr_en, rd_en, empty;
  logic [WIDTH-1:0] ram_rdata;

  assign empty = (count_q == '0);
  // Upstream holds in_valid while stalled, so only enabled cycles count.
  assign push  = in_valid && pipe_en_q;

`ifdef PIPE_DRAIN_BYPASS_EN
  logic bypass;
  assign bypass    = push && empty && !flush;
  assign out_valid = !empty || bypass;
  assign out_data  = empty ? in_data : ram_rdata;
  // A bypassed word taken downstream in the same cycle is never stored.
  assign wr_en     = push && !(bypass && out_ready);
`else
  assign out_valid = !empty;
  assign out_data  = ram_rdata;
  assign wr_en     = push;
`endif

  // Stored-entry pop; out_ready while empty does nothing.
  assign rd_en = !empty && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Explicit wrap so non-power-of-two depths work.
      if (wr_en) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      if (wr_en && !rd_en) begin
        count_d = count_q + CntW'(1);
      end else if (!wr_en && rd_en) begin
        count_d = count_q - CntW'(1);
      end
    end
    // Looking at next occupancy keeps pipe_en low before a push could overflow.
    pipe_en_d = (count_d < FullCnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pipe_en_q <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pipe_en_q <= pipe_en_d;
    end
  end

  assign pipe_en = pipe_en_q;
  assign count   = count_q;

  pipe_drain_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en && !flush),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

endmodule

// File: doc/pipe_drain_buf.md
PIPE_DRAIN_BUF -- requirements
Module: pipe_drain_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data bit width.
REQ-002 SHALL have parameter DEPTH, default 4, buffer entries (legal 2..64).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  WIDTH  tail data of the upstream enable-stalled pipeline.
REQ-006 SHALL have port in_valid  input  1  tail data is meaningful.
REQ-007 SHALL have port pipe_en  output  1  registered advance enable fanned out to every upstream pipeline stage.
REQ-008 SHALL have port flush  input  1  synchronous clear of buffered data.
REQ-009 SHALL have port out_data  output  WIDTH  head-of-buffer data.
REQ-010 SHALL have port out_valid  output  1  head entry available.
REQ-011 SHALL have port out_ready  input  1  downstream accepts head.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-013 SHALL push in_data when in_valid && pipe_en in the same cycle; in_valid while pipe_en=0 is ignored, because upstream holds it.
REQ-014 SHALL pop the head when out_valid && out_ready.
REQ-015 SHALL drive pipe_en from a flop whose next value = (count_next < DEPTH), so a push never occurs when full.
REQ-016 SHALL present first-word-fall-through output: out_valid = (count != 0), out_data = oldest entry.
REQ-017 SHALL give 1-cycle push-to-out_valid latency when empty (bypass disabled).
REQ-018 SHALL handle push and pop in the same cycle: count unchanged, order preserved.
REQ-019 SHALL wrap read/write pointers modulo DEPTH, for any DEPTH, including non-power-of-two.
REQ-020 SHALL give flush priority over simultaneous push/pop: count=0, pointers=0, pipe_en=1 the next cycle; the flushed push is lost.
REQ-021 SHALL never underflow: out_ready with out_valid=0 has no effect.
REQ-022 SHALL keep out_data stable while out_valid && !out_ready.

Reset
REQ-023 SHALL, on rst_n low, asynchronously clear count=0, pointers=0, out_valid=0 and set pipe_en=1.
REQ-024 SHALL leave storage contents unreset; out_data is don't-care while out_valid=0.
REQ-025 SHALL discard all buffered data when reset asserts mid-operation.

Configuration
REQ-026 SHALL, with PIPE_DRAIN_BYPASS_EN defined, forward in_data to the output combinationally when count=0 and a push occurs: out_valid=1 in the same cycle.
REQ-027 SHALL, with PIPE_DRAIN_BYPASS_EN defined, not store a bypassed word accepted by out_ready in the same cycle (count stays 0).
REQ-028 SHALL, without PIPE_DRAIN_BYPASS_EN, behave per REQ-017, with no combinational in-to-out path.

Structure
REQ-029 SHALL take pointer/count width helpers and the default DEPTH constant from shared package rast_pipe_pkg.
REQ-030 SHALL instantiate a single storage sub-module pipe_drain_ram (DEPTH x WIDTH register array: one write port, one async read port).
REQ-031 SHALL keep pointer, count and pipe_en logic in pipe_drain_buf.

Verification
REQ-032 SHALL cover fill-to-full: DEPTH=4, out_ready=0, in_valid=1 with data 1..6 -> four pushes (1..4); pipe_en=0 the cycle after the 4th push; count=4; 5 held upstream.
REQ-033 SHALL cover drain after full: from that full state, out_ready=1 -> out_data 1,2,3,4 on consecutive cycles; pipe_en=1 one cycle after the first pop; 5 then pushed.
REQ-034 SHALL cover streaming: in_valid=1, out_ready=1 continuously -> one word per cycle in order, count constant, pipe_en never drops.
REQ-035 SHALL cover flush: flush at count=3 with a simultaneous push -> next cycle count=0, out_valid=0, pipe_en=1; the pushed word never appears.
REQ-036 SHALL cover async reset: rst_n low mid-burst, between clock edges -> out_valid=0, count=0, pipe_en=1 immediately, without waiting for a clock edge.
REQ-037 SHALL cover bypass: with PIPE_DRAIN_BYPASS_EN, empty buffer, push 0xA5 with out_ready=1 -> out_valid=1 with out_data=0xA5 in the same cycle; count stays 0.
